volatility_rd_ctrl: RTL
=======================

Name: volatility_rd_ctrl

Overview:
- Read-side controller for the per-stock circular sample buffers in the volatility memory (NUM_STOCKS segments of BUFFER_SIZE entries each).
- Tracks each stock's write pointer and fill level by snooping write-address events.
- On request, streams the stock's stored window, oldest to newest, from the memory read port to the variance/volatility datapath using a valid/ready handshake.

Parameters:
- NUM_STOCKS, 4, number of stocks (buffer segments).
- BUFFER_SIZE, 20, entries per stock segment; stock s occupies addresses s*BUFFER_SIZE .. s*BUFFER_SIZE+BUFFER_SIZE-1.
- DATA_WIDTH, 32, sample width.
- Derived: SID_W=$clog2(NUM_STOCKS), ADDR_W=$clog2(NUM_STOCKS*BUFFER_SIZE), CNT_W=$clog2(BUFFER_SIZE+1).

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  reset, synchronous, active-low
- i_wr_valid  in  1  one sample written to memory this cycle
- i_wr_stock_id  in  SID_W  stock of the snooped write
- i_req_valid  in  1  readout request
- i_req_stock_id  in  SID_W  stock to read out
- o_req_ready  out  1  request accepted when i_req_valid & o_req_ready
- o_rd_en  out  1  memory read strobe
- o_rd_addr  out  ADDR_W  memory read address
- i_rd_data  in  DATA_WIDTH  memory read data, valid exactly 1 cycle after o_rd_en
- o_sample  out  DATA_WIDTH  streamed sample
- o_sample_valid  out  1  o_sample valid
- o_sample_last  out  1  final sample of the window, qualified by o_sample_valid
- i_sample_ready  in  1  downstream accepts sample
- o_done  out  1  one-cycle pulse at the end of each readout, including empty ones
- o_count  out  CNT_W  number of samples in the current or last readout

Behaviour:
- Reset (synchronous, i_reset_n=0 at posedge):
  - State returns to IDLE; all per-stock wr_ptr and fill_cnt clear to 0.
  - o_rd_en=0, o_rd_addr=0, o_sample=0, o_sample_valid=0, o_sample_last=0, o_done=0, o_count=0.
  - Reset mid-readout abandons the readout; no o_done is produced.
- Write tracking (every cycle, in any state) on i_wr_valid:
  - wr_ptr[id] <= (wr_ptr[id]==BUFFER_SIZE-1) ? 0 : wr_ptr[id]+1.
  - fill_cnt[id] increments, saturating at BUFFER_SIZE.
- o_req_ready = (state==IDLE). It is a decode of registered state only.
- On request acceptance, snapshot using values from before any same-cycle write:
  - len = fill_cnt[sid].
  - off = (fill_cnt<BUFFER_SIZE) ? 0 : wr_ptr[sid].
  - base = sid*BUFFER_SIZE.
  - o_count <= len; idx <= 0.
  - Next state: len==0 -> DONE; otherwise ISSUE.
- Later writes to the same stock during readout update tracking but do not alter the snapshot. Data overwritten mid-readout is returned as read; it is not flagged.
- FSM states:
  - IDLE: wait for request.
  - ISSUE: o_rd_en=1 for exactly one cycle; o_rd_addr=base+((off+idx) mod BUFFER_SIZE). Wrap uses compare-and-subtract, no divider. -> CAPTURE.
  - CAPTURE: o_sample<=i_rd_data; o_sample_valid<=1; o_sample_last<=(idx==len-1). -> OUT.
  - OUT: hold o_sample, o_sample_valid and o_sample_last stable while i_sample_ready=0. On handshake:
    - o_sample_valid<=0.
    - If last -> DONE; else idx<=idx+1 -> ISSUE.
  - DONE: o_done=1 for one cycle. -> IDLE.
- Latency:
  - Request accept to first o_rd_en: 1 cycle.
  - o_rd_en to o_sample_valid: 2 cycles.
  - Throughput: 1 sample per 3 cycles with ready held high.
- o_rd_en is never asserted outside ISSUE. Only one read is outstanding at a time.
- i_req_valid while not in IDLE is ignored. The requester must hold i_req_valid until accepted.
- All outputs are registered except o_req_ready.

Test Plan:
1. Reset, then request stock 1 with no prior writes -> accepted; o_rd_en never asserts; o_count=0; o_done pulses 2 cycles after accept; no o_sample_valid.
2. 3 writes to stock 2, then request stock 2 -> o_rd_addr 40, 41, 42; samples out in that order; o_sample_last only on the third; o_count=3; o_done follows the last handshake.
3. 25 writes to stock 0 (fill_cnt saturates at 20, wr_ptr=5), request stock 0 -> 20 reads at addresses 5..19 then 0..4; last flagged at address 4.
4. Backpressure: i_sample_ready low for 4 cycles on sample 2 -> o_sample and o_sample_valid held stable; no o_rd_en until the handshake; data order unchanged.
5. Write to stock 3 in the same cycle as a request for stock 3 (prior fill 2) -> o_count=2 and 2 samples out; a second request afterwards -> o_count=3.
6. Assert reset during OUT of a 5-sample readout -> all outputs 0 the following cycle; o_req_ready=1; no o_done; a subsequent request for the same stock -> o_count=0.

Source files
------------

// File: rtl/volatility_rd_ctrl.sv
// Read-side controller for the per-stock circular sample buffers.
// Snoops write events to track each stock's write pointer and fill level, and on
// request streams the stored window (oldest to newest) out over valid/ready.
module volatility_rd_ctrl #(
    parameter int unsigned NUM_STOCKS  = 4,
    parameter int unsigned BUFFER_SIZE = 20,
    parameter int unsigned DATA_WIDTH  = 32,
    localparam int unsigned SID_W  = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1,
    localparam int unsigned ADDR_W = $clog2(NUM_STOCKS * BUFFER_SIZE),
    localparam int unsigned CNT_W  = $clog2(BUFFER_SIZE + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_wr_valid,
    input  logic [SID_W-1:0]      i_wr_stock_id,
    input  logic                  i_req_valid,
    input  logic [SID_W-1:0]      i_req_stock_id,
    output logic                  o_req_ready,
    output logic                  o_rd_en,
    output logic [ADDR_W-1:0]     o_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic [DATA_WIDTH-1:0] o_sample,
    output logic                  o_sample_valid,
    output logic                  o_sample_last,
    input  logic                  i_sample_ready,
    output logic                  o_done,
    output logic [CNT_W-1:0]      o_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_OUT,
        ST_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        wr_ptr_q [NUM_STOCKS];
    logic [CNT_W-1:0]        wr_ptr_d [NUM_STOCKS];
    logic [CNT_W-1:0]        fill_q   [NUM_STOCKS];
    logic [CNT_W-1:0]        fill_d   [NUM_STOCKS];
    logic [ADDR_W-1:0]       base_q, base_d;
    logic [CNT_W-1:0]        off_q, off_d;
    logic [CNT_W-1:0]        len_q, len_d;
    logic [CNT_W-1:0]        idx_q, idx_d;
    logic                    rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]       rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0]   sample_q, sample_d;
    logic                    sample_valid_q, sample_valid_d;
    logic                    sample_last_q, sample_last_d;
    logic                    done_q, done_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [CNT_W:0]          wrap_sum;

    // Request acceptance is a pure decode of the registered state.
    assign o_req_ready    = (state_q == ST_IDLE);
    assign o_rd_en        = rd_en_q;
    assign o_rd_addr      = rd_addr_q;
    assign o_sample       = sample_q;
    assign o_sample_valid = sample_valid_q;
    assign o_sample_last  = sample_last_q;
    assign o_done         = done_q;
    assign o_count        = count_q;

    // Next-state: write tracking, readout sequencing and registered outputs.
    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        fill_d         = fill_q;
        base_d         = base_q;
        off_d          = off_q;
        len_d          = len_q;
        idx_d          = idx_q;
        rd_en_d        = 1'b0;
        rd_addr_d      = rd_addr_q;
        sample_d       = sample_q;
        sample_valid_d = sample_valid_q;
        sample_last_d  = sample_last_q;
        done_d         = 1'b0;
        count_d        = count_q;
        wrap_sum       = '0;

        // Snooped writes advance the stock's pointer and fill in every state.
        if (i_wr_valid) begin
            wr_ptr_d[i_wr_stock_id] = (wr_ptr_q[i_wr_stock_id] == CNT_W'(BUFFER_SIZE - 1))
                                      ? '0 : wr_ptr_q[i_wr_stock_id] + CNT_W'(1);
            if (fill_q[i_wr_stock_id] != CNT_W'(BUFFER_SIZE)) begin
                fill_d[i_wr_stock_id] = fill_q[i_wr_stock_id] + CNT_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                // Snapshot uses the pre-write values so a same-cycle write is excluded.
                if (i_req_valid) begin
                    len_d   = fill_q[i_req_stock_id];
                    off_d   = (fill_q[i_req_stock_id] < CNT_W'(BUFFER_SIZE))
                              ? '0 : wr_ptr_q[i_req_stock_id];
                    base_d  = ADDR_W'(i_req_stock_id) * ADDR_W'(BUFFER_SIZE);
                    idx_d   = '0;
                    count_d = fill_q[i_req_stock_id];
                    state_d = (fill_q[i_req_stock_id] == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                sample_d       = i_rd_data;
                sample_valid_d = 1'b1;
                sample_last_d  = (idx_q == len_q - CNT_W'(1));
                state_d        = ST_OUT;
            end
            ST_OUT: begin
                if (i_sample_ready) begin
                    sample_valid_d = 1'b0;
                    if (sample_last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + CNT_W'(1);
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Strobe and address are launched as ISSUE is entered so they are live during ISSUE.
        if (state_d == ST_ISSUE) begin
            wrap_sum = (CNT_W+1)'(off_d) + (CNT_W+1)'(idx_d);
            if (wrap_sum >= (CNT_W+1)'(BUFFER_SIZE)) begin
                wrap_sum = wrap_sum - (CNT_W+1)'(BUFFER_SIZE);
            end
            rd_en_d   = 1'b1;
            rd_addr_d = base_d + ADDR_W'(wrap_sum);
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q        <= ST_IDLE;
            for (int s = 0; s < int'(NUM_STOCKS); s++) begin
                wr_ptr_q[s] <= '0;
                fill_q[s]   <= '0;
            end
            base_q         <= '0;
            off_q          <= '0;
            len_q          <= '0;
            idx_q          <= '0;
            rd_en_q        <= 1'b0;
            rd_addr_q      <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            sample_last_q  <= 1'b0;
            done_q         <= 1'b0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            fill_q         <= fill_d;
            base_q         <= base_d;
            off_q          <= off_d;
            len_q          <= len_d;
            idx_q          <= idx_d;
            rd_en_q        <= rd_en_d;
            rd_addr_q      <= rd_addr_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            sample_last_q  <= sample_last_d;
            done_q         <= done_d;
            count_q        <= count_d;
        end
    end

endmodule
